alu_slice_serial: RTL and testbench
===================================

Name: alu_slice_serial

Overview:
- Parametrised, multi-cycle ALU. Processes WIDTH-bit operands SLICE bits per clock, LSB slice first, with the carry registered between slices.
- Generalises the 1-bit ALU cell to arbitrary width, adds subtract, SLT and flags, and wraps it in a valid/ready handshake.
- Sits between the decode/operand stage and writeback. Used where area matters more than single-cycle latency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; 1..WIDTH. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands/op presented
- in_ready  output  1  block can accept (IDLE only)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_op  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result
- result  output  WIDTH  operation result
- carry_out  output  1  carry out of MSB (ADD/SUB/SLT), else 0
- zero  output  1  result == 0
- overflow  output  1  signed overflow (ADD/SUB), else 0
- illegal_op  output  1  alu_op not in the encoding list

Behaviour:
- Reset (sync, active-high), checked at every rising edge; overrides everything including mid-RUN and DONE:
  - state=IDLE, in_ready=1, out_valid=0.
  - result=0, carry_out=0, zero=0, overflow=0, illegal_op=0, slice counter=0.
  - Any in-flight operation is discarded; no out_valid is produced for it.
- FSM states and transitions:
  - IDLE: in_ready=1. in_valid&&in_ready at an edge latches a, b, alu_op into internal registers. Next state RUN, counter=0.
  - Carry register on accept: 1 for SUB/SLT (B inverted, two's complement); 0 otherwise.
  - RUN: in_ready=0. Each edge computes slice k = counter, bits [k*SLICE +: SLICE], into the result register. Carry register updates from the slice's MSB carry. Counter increments.
  - RUN exit: on the edge processing slice NSLICE-1, next state DONE. Flags are computed on that same edge.
  - DONE: out_valid=1; result and flags stable. On an edge with out_ready=1, next state IDLE and out_valid drops.
  - No accept in the DONE->IDLE cycle (in_ready is 0 in DONE).
- Latency: accept at edge E0; slices on E1..E_NSLICE; out_valid high after E_NSLICE. With out_ready held high, back-to-back throughput is one op per NSLICE+2 cycles.
- Inputs a/b/alu_op may change freely after accept; only latched copies are used.
- Arithmetic:
  - ADD: result = a+b mod 2^WIDTH. SUB: result = a+~b+1.
  - carry_out = final carry. For SUB, 1 means no borrow.
  - overflow = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' is b for ADD and ~b for SUB.
- SLT: runs the SUB datapath. Final result = {WIDTH-1 zeros, lt}, where lt = diff[MSB] XOR ovf. SLT reports carry_out=0 and overflow=0.
- AND/OR/NOR: bitwise per slice; carry_out=0, overflow=0.
- Illegal alu_op: the op is accepted and runs the normal NSLICE cycles. result=0, zero=1, illegal_op=1, other flags 0.
- zero is evaluated on the final result in DONE.
- SLICE==WIDTH: NSLICE=1; the block degenerates to a single RUN cycle.

Test Plan (WIDTH=8, SLICE=2, NSLICE=4):
- ADD a=0xF0, b=0x20, out_ready=1 -> out_valid exactly 4 cycles after accept; result=0x10, carry_out=1, overflow=0, zero=0.
- SUB a=0x80, b=0x01 -> result=0x7F, carry_out=1, overflow=1. Then SLT a=0x80, b=0x01 -> result=0x01. SLT a=0x01, b=0x80 -> result=0x00, zero=1.
- NOR a=0x0F, b=0xF0 -> result=0x00, zero=1, carry_out=0. Change a/b during RUN -> result unchanged.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and result held stable, in_ready=0. Then out_ready=1 -> IDLE next cycle, new op accepted the cycle after.
- Reset asserted on the 2nd RUN cycle of ADD 0xFF+0x01 -> next cycle IDLE, in_ready=1, all outputs 0, no out_valid ever seen for that op.
- alu_op=0101 -> after 4 cycles: illegal_op=1, result=0x00, zero=1. The next legal op clears illegal_op.

Source files
------------

// File: rtl/alu_slice_serial.sv
`default_nettype none
// ============================================================================
//  Module      : alu_slice_serial
//  Description : Multi-cycle ALU that walks WIDTH-bit operands SLICE bits per
//                clock (LSB first) behind a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_slice_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow,
    output logic             illegal_op
);
    localparam int c_NSLICE = WIDTH / SLICE;
    localparam int c_CW     = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NSLICE - 1);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [3:0]        r_op;
    logic              r_carry;
    logic [c_CW-1:0]   r_cnt;

    logic              w_accept;
    logic              w_run;
    logic              w_last;
    logic              w_sub_in;
    logic [SLICE-1:0]  w_a_sl;
    logic [SLICE-1:0]  w_b_sl;
    logic [SLICE:0]    w_sum_ext;
    logic [SLICE-1:0]  w_slice_res;
    logic [WIDTH-1:0]  w_res_full;
    logic              w_ovf;
    logic              w_lt;
    logic [WIDTH-1:0]  w_fin_res;
    logic              w_fin_c;
    logic              w_fin_v;
    logic              w_fin_ill;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (r_cnt == c_LAST) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = in_valid & in_ready;
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_cnt == c_LAST);
    assign w_sub_in = (alu_op == c_OP_SUB) || (alu_op == c_OP_SLT);

    // Operands shift right each cycle, so the active slice is always the LSBs.
    assign w_a_sl    = r_a[SLICE-1:0];
    assign w_b_sl    = r_b[SLICE-1:0];
    assign w_sum_ext = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
    assign w_ovf     = (w_a_sl[SLICE-1] == w_b_sl[SLICE-1]) &&
                       (w_sum_ext[SLICE-1] != w_a_sl[SLICE-1]);
    assign w_lt      = w_sum_ext[SLICE-1] ^ w_ovf;

    always_comb begin
        w_slice_res = '0;
        case (r_op)
            c_OP_AND:                     w_slice_res = w_a_sl & w_b_sl;
            c_OP_OR:                      w_slice_res = w_a_sl | w_b_sl;
            c_OP_NOR:                     w_slice_res = ~(w_a_sl | w_b_sl);
            c_OP_ADD, c_OP_SUB, c_OP_SLT: w_slice_res = w_sum_ext[SLICE-1:0];
            default:                      w_slice_res = '0;
        endcase
    end

    // Result fills from the top; after NSLICE shifts slice 0 sits at the LSBs.
    generate
        if (SLICE == WIDTH) begin : g_single
            assign w_res_full = w_slice_res;
        end else begin : g_multi
            assign w_res_full = {w_slice_res, result[WIDTH-1:SLICE]};
        end
    endgenerate

    always_comb begin
        w_fin_res = w_res_full;
        w_fin_c   = 1'b0;
        w_fin_v   = 1'b0;
        w_fin_ill = 1'b0;
        case (r_op)
            c_OP_ADD, c_OP_SUB: begin
                w_fin_c = w_sum_ext[SLICE];
                w_fin_v = w_ovf;
            end
            c_OP_SLT:                     w_fin_res = WIDTH'(w_lt);
            c_OP_AND, c_OP_OR, c_OP_NOR: begin
                w_fin_res = w_res_full;
            end
            default: begin
                w_fin_res = '0;
                w_fin_ill = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            result     <= '0;
            carry_out  <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            illegal_op <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_sub_in ? ~b : b;
            r_op    <= alu_op;
            r_carry <= w_sub_in;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> SLICE;
            r_b     <= r_b >> SLICE;
            r_carry <= w_sum_ext[SLICE];
            r_cnt   <= r_cnt + c_CW'(1);
            if (w_last) begin
                result     <= w_fin_res;
                carry_out  <= w_fin_c;
                zero       <= (w_fin_res == '0);
                overflow   <= w_fin_v;
                illegal_op <= w_fin_ill;
            end else begin
                result <= w_res_full;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_slice_serial.sv
`default_nettype none
// Testbench for alu_slice_serial: directed ops, scoreboard queue checked by
// an independent output monitor.
module tb_alu_slice_serial;
    localparam int WIDTH = 8;
    localparam int SLICE = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;
    logic             overflow;
    logic             illegal_op;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   errors = 0;
    int   checks = 0;

    alu_slice_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .alu_op     (alu_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carry_out  (carry_out),
        .zero       (zero),
        .overflow   (overflow),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] r, input logic c, z, v, ill);
        mk = {r, c, z, v, ill};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every completed output handshake is compared against the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual=%h required=none",
                         {result, carry_out, zero, overflow, illegal_op});
            end else begin
                m_e = sb.pop_front();
                if ({result, carry_out, zero, overflow, illegal_op} !== m_e) begin
                    errors++;
                    $display("FAIL scoreboard actual(res,c,z,v,ill)=%h,%b%b%b%b required=%h,%b%b%b%b",
                             result, carry_out, zero, overflow, illegal_op,
                             m_e.res, m_e.c, m_e.z, m_e.v, m_e.ill);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb,
                         input bit push, input exp_t e);
        bit rdy;
        int n;
        n = 0;
        if (push) sb.push_back(e);
        a = aa; b = bb; alu_op = op; in_valid = 1'b1;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 40) begin
                checks++; errors++;
                $display("FAIL accept_timeout actual=%0b required=1", in_ready);
                break;
            end
            #1;
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 60);
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual=%0b required=1", in_ready);
        end
    endtask

    initial begin
        bit seen;
        int n;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; alu_op = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", 32'({result, carry_out, zero, overflow, illegal_op}), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // ADD with latency: out_valid must rise exactly after the 4th slice edge
        issue(4'b0010, 8'hF0, 8'h20, 1, mk(8'h10, 1, 0, 0, 0));
        repeat (4) @(negedge clk);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        wait_idle();

        issue(4'b0110, 8'h80, 8'h01, 1, mk(8'h7F, 1, 0, 1, 0)); wait_idle();
        issue(4'b0111, 8'h80, 8'h01, 1, mk(8'h01, 0, 0, 0, 0)); wait_idle();
        issue(4'b0111, 8'h01, 8'h80, 1, mk(8'h00, 0, 1, 0, 0)); wait_idle();

        // NOR with operands scrambled while running
        issue(4'b1100, 8'h0F, 8'hF0, 1, mk(8'h00, 0, 1, 0, 0));
        a = 8'hAA; b = 8'h55; alu_op = 4'b0010;
        wait_idle();

        // Backpressure in DONE
        out_ready = 1'b0;
        issue(4'b0001, 8'h35, 8'h0A, 1, mk(8'h3F, 0, 0, 0, 0));
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_reached_done", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_result_hold", 32'(result), 32'h3F);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        issue(4'b0000, 8'h3C, 8'h0F, 1, mk(8'h0C, 0, 0, 0, 0));
        chk("bp_next_accepted", 32'(in_ready), 32'd0);
        wait_idle();

        // Reset during the 2nd RUN cycle discards the op
        issue(4'b0010, 8'hFF, 8'h01, 0, mk(8'h00, 0, 0, 0, 0));
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_outputs", 32'({result, carry_out, zero, overflow, illegal_op}), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        chk("mid_rst_no_valid", 32'(seen), 32'd0);

        // Illegal op, then a legal op must clear the flag
        issue(4'b0101, 8'h12, 8'h34, 1, mk(8'h00, 0, 1, 0, 1)); wait_idle();
        chk("ill_flag_hold", 32'(illegal_op), 32'd1);
        issue(4'b0010, 8'h7F, 8'h01, 1, mk(8'h80, 0, 0, 1, 0)); wait_idle();
        issue(4'b0110, 8'h05, 8'h05, 1, mk(8'h00, 1, 1, 0, 0)); wait_idle();
        issue(4'b0111, 8'hFE, 8'h03, 1, mk(8'h01, 0, 0, 0, 0)); wait_idle();

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
